// File: rtl/vector_data_packer_pkg.sv
// Shared helpers for the lebug trace path: config stream layout, count widths
// and the firmware lane-count decode used by the vector packer.
package lebug_pkg;

    function automatic int unsigned cfg_commit_offset();
        return 0;
    endfunction

    function automatic int unsigned cfg_size_offset(input int unsigned max_chains);
        return cfg_commit_offset() + max_chains;
    endfunction

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // A size of 0, or one wider than the vector, keeps every lane.
    function automatic int unsigned size_eff(input logic [7:0] size, input int unsigned n);
        if (size == 8'd0 || 32'(size) > n)
            return n;
        return 32'(size);
    endfunction

endpackage

// File: rtl/vector_data_packer_combine.sv
// Concatenates the buffered elements with the kept input lanes into a 2N-lane
// sequence; lanes past fill+take are zero so short words come out padded.
module pack_combine
    import lebug_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned CW        = count_width(N),
    localparam int unsigned IW        = $clog2(2 * N)
) (
    input  logic [N-1:0][DATA_WIDTH-1:0]   hold,
    input  logic [CW-1:0]                  fill,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    input  logic [CW-1:0]                  take,
    output logic [2*N-1:0][DATA_WIDTH-1:0] combined
);

    always_comb begin
        combined = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i < 32'(fill))
                combined[i] = hold[i];
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (j < 32'(take))
                combined[IW'(j) + IW'(fill)] = vector_in[j];
        end
    end

endmodule

// File: rtl/vector_data_packer.sv
// Packs the kept lanes of each traced vector into dense N-lane words for the
// trace buffer; per-chain firmware arrives on the configId/configData stream.
module vector_data_packer
    import lebug_pkg::*;
#(
    parameter int unsigned                N                       = 8,
    parameter int unsigned                DATA_WIDTH              = 32,
    parameter int unsigned                MAX_CHAINS              = 4,
    parameter logic [7:0]                 PERSONAL_CONFIG_ID      = 8'd0,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_COMMIT = {MAX_CHAINS{8'd1}},
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_SIZE   = '0,
    localparam int unsigned               CW                      = count_width(N),
    localparam int unsigned               IDW                     = $clog2(MAX_CHAINS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         tracing,
    input  logic                         valid_in,
    input  logic [1:0]                   eof_in,
    input  logic [1:0]                   bof_in,
    input  logic [IDW-1:0]               chainId_in,
    input  logic [7:0]                   configId,
    input  logic [7:0]                   configData,
    input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
    output logic [CW-1:0]                count_out,
    output logic                         valid_out,
    output logic                         bof_out
);

    localparam int unsigned    CCW    = $clog2(2 * N + 1);
    localparam int unsigned    BCW    = $clog2(2 * MAX_CHAINS + 1);
    localparam logic [CCW-1:0] N_C    = CCW'(N);
    localparam logic [BCW-1:0] BC_MAX = BCW'(2 * MAX_CHAINS);

    logic [N-1:0][DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [CW-1:0]                  fill_q, fill_d;
    logic                           flush_pending_q, flush_pending_d;
    logic                           first_word_q;
    logic [BCW-1:0]                 byte_counter_q;
    logic [MAX_CHAINS-1:0][7:0]     commit_q, size_q;

    logic                           accepted, eof_hit, emit;
    logic [CW-1:0]                  take, emit_cnt;
    logic [CCW-1:0]                 comb_cnt;
    logic [2*N-1:0][DATA_WIDTH-1:0] combined;

    logic unused_flags;
    assign unused_flags = ^{bof_in, eof_in[0]};

    assign accepted = tracing && valid_in && (commit_q[chainId_in] != 8'd0);
    assign take     = accepted ? CW'(size_eff(size_q[chainId_in], N)) : '0;
    assign comb_cnt = CCW'(fill_q) + CCW'(take);
    assign eof_hit  = accepted && eof_in[1];

    pack_combine #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_combine (
        .hold      (hold_q),
        .fill      (fill_q),
        .vector_in (vector_in),
        .take      (take),
        .combined  (combined)
    );

    always_comb begin
        hold_d          = hold_q;
        fill_d          = fill_q;
        flush_pending_d = flush_pending_q;
        emit            = 1'b0;
        emit_cnt        = '0;
        if (comb_cnt >= N_C) begin
            emit            = 1'b1;
            emit_cnt        = CW'(N);
            fill_d          = CW'(comb_cnt - N_C);
            hold_d          = combined[2*N-1:N];
            // A flush that overflows a full word finishes on the following cycle.
            flush_pending_d = (eof_hit || flush_pending_q) && (fill_d != '0);
        end else if (eof_hit || flush_pending_q) begin
            emit            = (comb_cnt != '0);
            emit_cnt        = CW'(comb_cnt);
            fill_d          = '0;
            flush_pending_d = 1'b0;
        end else if (!tracing && fill_q != '0) begin
            emit     = 1'b1;
            emit_cnt = fill_q;
            fill_d   = '0;
        end else begin
            hold_d = combined[N-1:0];
            fill_d = CW'(comb_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q          <= '0;
            fill_q          <= '0;
            flush_pending_q <= 1'b0;
            first_word_q    <= 1'b1;
            byte_counter_q  <= '0;
            commit_q        <= INITIAL_FIRMWARE_COMMIT;
            size_q          <= INITIAL_FIRMWARE_SIZE;
            vector_out      <= '0;
            count_out       <= '0;
            valid_out       <= 1'b0;
            bof_out         <= 1'b0;
        end else begin
            hold_q          <= hold_d;
            fill_q          <= fill_d;
            flush_pending_q <= flush_pending_d;
            valid_out       <= emit;
            bof_out         <= emit && first_word_q;
            if (emit) begin
                vector_out   <= combined[N-1:0];
                count_out    <= emit_cnt;
                first_word_q <= (emit_cnt < CW'(N));
            end
            if (!tracing) begin
                if (configId == PERSONAL_CONFIG_ID) begin
                    for (int unsigned k = 0; k < MAX_CHAINS; k++) begin
                        if (byte_counter_q == BCW'(cfg_commit_offset() + k))
                            commit_q[k] <= configData;
                        if (byte_counter_q == BCW'(cfg_size_offset(MAX_CHAINS) + k))
                            size_q[k] <= configData;
                    end
                    if (byte_counter_q != BC_MAX)
                        byte_counter_q <= byte_counter_q + BCW'(1);
                end else begin
                    byte_counter_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_data_packer.sv
// Directed bench for vector_data_packer: a queue-based reference model checked
// every cycle, plus literal word expectations at the key points.
module tb_vector_data_packer;
    import lebug_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MC = 4;
    localparam int unsigned CW = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 tracing = 1'b0;
    logic                 valid_in = 1'b0;
    logic [1:0]           eof_in = '0;
    logic [1:0]           bof_in = '0;
    logic [1:0]           chainId_in = '0;
    logic [7:0]           configId = 8'hFF;
    logic [7:0]           configData = '0;
    logic [N-1:0][DW-1:0] vector_in = '0;
    logic [N-1:0][DW-1:0] vector_out;
    logic [CW-1:0]        count_out;
    logic                 valid_out;
    logic                 bof_out;

    int   tests = 0;
    int   fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    vector_data_packer #(
        .N                  (N),
        .DATA_WIDTH         (DW),
        .MAX_CHAINS         (MC),
        .PERSONAL_CONFIG_ID (8'd0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tracing    (tracing),
        .valid_in   (valid_in),
        .eof_in     (eof_in),
        .bof_in     (bof_in),
        .chainId_in (chainId_in),
        .configId   (configId),
        .configData (configData),
        .vector_in  (vector_in),
        .vector_out (vector_out),
        .count_out  (count_out),
        .valid_out  (valid_out),
        .bof_out    (bof_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: element queue plus firmware tables.
    logic [31:0]          mq[$];
    logic                 m_pend, m_fw;
    int unsigned          m_bc;
    logic [7:0]           m_commit[MC];
    logic [7:0]           m_size[MC];
    logic [N-1:0][DW-1:0] exp_vec = '0;
    logic [CW-1:0]        exp_cnt = '0;
    logic                 exp_valid = 1'b0;
    logic                 exp_bof = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model
        int unsigned s, nemit;
        logic        acc, eof;
        if (!reset_n) begin
            mq.delete();
            m_pend = 1'b0;
            m_fw   = 1'b1;
            m_bc   = 0;
            for (int k = 0; k < MC; k++) begin
                m_commit[k] = 8'd1;
                m_size[k]   = 8'd0;
            end
            exp_vec   = '0;
            exp_cnt   = '0;
            exp_valid = 1'b0;
            exp_bof   = 1'b0;
        end else begin
            acc = tracing && valid_in && (m_commit[chainId_in] != 8'd0);
            s   = 0;
            if (acc)
                s = (m_size[chainId_in] == 8'd0 || m_size[chainId_in] > N) ? N : m_size[chainId_in];
            for (int unsigned j = 0; j < s; j++)
                mq.push_back(vector_in[j]);
            eof   = acc && eof_in[1];
            nemit = 0;
            if (mq.size() >= N) begin
                nemit  = N;
                m_pend = (eof || m_pend) && (mq.size() > N);
            end else if (eof || m_pend) begin
                nemit  = mq.size();
                m_pend = 1'b0;
            end else if (!tracing) begin
                nemit = mq.size();
            end
            exp_valid = (nemit > 0);
            exp_bof   = 1'b0;
            if (nemit > 0) begin
                exp_vec = '0;
                for (int unsigned j = 0; j < nemit; j++)
                    exp_vec[j] = mq.pop_front();
                exp_cnt = CW'(nemit);
                exp_bof = m_fw;
                m_fw    = (nemit < N);
            end
            if (!tracing) begin
                if (configId == 8'd0) begin
                    if (m_bc < MC)            m_commit[m_bc]  = configData;
                    else if (m_bc < 2 * MC)   m_size[m_bc - MC] = configData;
                    if (m_bc < 2 * MC) m_bc++;
                end else begin
                    m_bc = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_out", valid_out, exp_valid);
            chk("bof_out", bof_out, exp_bof);
            chk("count_out", count_out, exp_cnt);
            tests++;
            if (vector_out !== exp_vec) begin
                fails++;
                $display("FAIL vector_out: got %h expected %h", vector_out, exp_vec);
            end
        end
    end

    task automatic drive(input logic tr, input logic v, input logic eof1,
                         input int unsigned ch, input logic [31:0] base);
        tracing    = tr;
        valid_in   = v;
        eof_in     = {eof1, 1'b0};
        bof_in     = {1'b0, eof1};
        chainId_in = ch[1:0];
        configId   = 8'hFF;
        configData = '0;
        for (int unsigned j = 0; j < N; j++)
            vector_in[j] = base + j;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] b[8]);
        for (int k = 0; k < 9; k++) begin
            tracing    = 1'b0;
            valid_in   = 1'b0;
            configId   = 8'h00;
            configData = (k < 8) ? b[k] : 8'hEE;
            @(posedge clk);
            #1;
        end
        configId = 8'hFF;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input string tag, input logic [3:0] cnt, input logic bof,
                        input int ia, input logic [31:0] va, input int ib, input logic [31:0] vb);
        chk({tag, "_valid"}, valid_out, 1'b1);
        chk({tag, "_count"}, count_out, cnt);
        chk({tag, "_bof"}, bof_out, bof);
        chk({tag, "_lane_a"}, vector_out[ia], va);
        chk({tag, "_lane_b"}, vector_out[ib], vb);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_count", count_out, 4'd0);
        chk("rst_bof", bof_out, 1'b0);
        chk("rst_vec", vector_out[0], 32'd0);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Full-size chain 0: each vector passes straight through.
        drive(1, 1, 0, 0, 32'h100); word("full1", 4'd8, 1'b1, 0, 32'h100, 7, 32'h107);
        drive(1, 1, 0, 0, 32'h200); word("full2", 4'd8, 1'b0, 0, 32'h200, 7, 32'h207);
        drive(1, 1, 0, 0, 32'h300); word("full3", 4'd8, 1'b0, 0, 32'h300, 7, 32'h307);
        drive(1, 1, 0, 0, 32'h400); word("full4", 4'd8, 1'b0, 0, 32'h400, 7, 32'h407);
        drive(0, 0, 0, 0, 0);

        // Chain 0 keeps 3 lanes.
        cfg('{8'd1, 8'd1, 8'd1, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0});
        drive(1, 1, 0, 0, 32'hA00); chk("s3_a_valid", valid_out, 1'b0);
        drive(1, 1, 0, 0, 32'hB00); chk("s3_b_valid", valid_out, 1'b0);
        drive(1, 1, 0, 0, 32'hC00);
        word("s3_abc", 4'd8, 1'b0, 2, 32'hA02, 3, 32'hB00);
        chk("s3_abc_l6", vector_out[6], 32'hC00);
        chk("s3_abc_l7", vector_out[7], 32'hC01);
        drive(1, 1, 1, 0, 32'hD00);
        word("s3_d", 4'd4, 1'b0, 0, 32'hC02, 3, 32'hD02);
        chk("s3_d_pad", vector_out[4], 32'd0);
        drive(1, 1, 1, 0, 32'hE00);
        word("s3_e", 4'd3, 1'b1, 2, 32'hE02, 3, 32'd0);

        // Flush overflowing a full word: F=6, chain 0 keeps 5, eof.
        cfg('{8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd6, 8'd0, 8'd0});
        drive(1, 1, 0, 1, 32'h1000); chk("ov_g_valid", valid_out, 1'b0);
        drive(1, 1, 1, 0, 32'h2000);
        word("ov_w1", 4'd8, 1'b1, 5, 32'h1005, 6, 32'h2000);
        drive(1, 0, 0, 0, 32'h0);
        word("ov_w2", 4'd3, 1'b0, 2, 32'h2004, 3, 32'd0);

        // Chain 0 disabled, chain 1 full size.
        cfg('{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0});
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 32'h3100 + 32'(k) * 32'h10);
            chk("drop_valid", valid_out, 1'b0);
        end
        drive(1, 1, 0, 1, 32'h3000);
        word("ch1_full", 4'd8, 1'b1, 0, 32'h3000, 7, 32'h3007);

        // Reset with F=5 and a pending flush.
        cfg('{8'd1, 8'd0, 8'd1, 8'd1, 8'd5, 8'd8, 8'd8, 8'd0});
        drive(1, 1, 0, 0, 32'h4000); chk("pre_valid", valid_out, 1'b0);
        drive(1, 1, 1, 2, 32'h5000);
        word("pre_w", 4'd8, 1'b0, 4, 32'h4004, 7, 32'h5002);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", valid_out, 1'b0);
        chk("arst_count", count_out, 4'd0);
        chk("arst_bof", bof_out, 1'b0);
        chk("arst_vec", vector_out[0], 32'd0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 0); chk("post_idle1", valid_out, 1'b0);
        drive(1, 0, 0, 0, 0); chk("post_idle2", valid_out, 1'b0);
        drive(1, 1, 0, 1, 32'h6000);
        word("post_ch1", 4'd8, 1'b1, 0, 32'h6000, 7, 32'h6007);
        drive(1, 1, 0, 0, 32'h7000);
        word("post_ch0", 4'd8, 1'b0, 0, 32'h7000, 7, 32'h7007);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
